apb_reg_bank: RTL

Parametrised APB4 slave register bank; successor of the fixed four-register APB front end of the codec.
- Provides NUM_REGS word registers with byte strobes, programmable wait states (PREADY), decode errors (PSLVERR) and a one-cycle start pulse on CTRL writes.
- Sits between the APB bus and the encoder/decoder core; the core consumes the flattened register outputs.

---
 rtl/apb_reg_bank.sv | 129 ++++++++++++
 1 files changed

// File: rtl/apb_reg_bank.sv
// apb_reg_bank: APB4 slave exposing NUM_REGS byte-strobed word registers with wait states and decode errors.
// Optional macro REG_LOCK_EN: CTRL bit AMBA_WORD-1 locks writes to every register except CTRL.
module apb_reg_bank #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int NUM_REGS        = 4,
    parameter int WAIT_STATES     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic                          PWRITE,
    input  logic [AMBA_ADDR_WIDTH-1:0]    PADDR,
    input  logic [AMBA_WORD-1:0]          PWDATA,
    input  logic [AMBA_WORD/8-1:0]        PSTRB,
    output logic [AMBA_WORD-1:0]          PRDATA,
    output logic                          PREADY,
    output logic                          PSLVERR,
    output logic [NUM_REGS*AMBA_WORD-1:0] regs_q,
    output logic [NUM_REGS-1:0]           wr_pulse,
    output logic                          start,
    output logic [1:0]                    dbg_state
);

    localparam int NB    = AMBA_WORD / 8;
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [3:0]           wait_cnt;
    logic [AMBA_WORD-1:0] regs [NUM_REGS];
    logic [IDX_W-1:0]     idx;
    logic                 dec_err;
    logic                 lock_err;
    logic                 err;
    logic                 commit;

    assign idx     = PADDR[IDX_W+1:2];
    assign dec_err = (PADDR[1:0] != 2'b00) || (32'(idx) >= NUM_REGS) ||
                     ((PADDR >> (IDX_W + 2)) != '0);

`ifdef REG_LOCK_EN
    assign lock_err = regs[0][AMBA_WORD-1] && PWRITE && (idx != '0);
`else
    assign lock_err = 1'b0;
`endif

    assign err = dec_err || lock_err;

    // Handshake: PSEL&PENABLE act as valid, PREADY as ready; a transfer commits on the
    // rising edge where valid and ready are both high. Dropping valid before then aborts it.
    assign PREADY    = (state == ACCESS) && (wait_cnt == 4'(WAIT_STATES));
    assign PSLVERR   = PREADY && err;
    assign commit    = PREADY && PSEL && PENABLE && PWRITE && !err;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) state_nxt = SETUP;
            end
            SETUP: begin
                if (!PSEL)        state_nxt = IDLE;
                else if (PENABLE) state_nxt = ACCESS;
            end
            ACCESS: begin
                if (!PSEL || !PENABLE || PREADY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 4'd0;
        end else if (state == SETUP && state_nxt == ACCESS) begin
            wait_cnt <= 4'd0;
        end else if (state == ACCESS && !PREADY) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit) begin
            for (int k = 0; k < NB; k++) begin
                if (PSTRB[k]) regs[idx][k*8 +: 8] <= PWDATA[k*8 +: 8];
            end
        end
    end

    // Pulses are registered so they appear in the cycle right after the commit edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_pulse <= '0;
            start    <= 1'b0;
        end else begin
            wr_pulse <= '0;
            start    <= commit && (idx == '0);
            if (commit) wr_pulse[idx] <= 1'b1;
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PREADY && !PWRITE && !err) PRDATA = regs[idx];
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_q[g*AMBA_WORD +: AMBA_WORD] = regs[g];
    end

endmodule
